// File: rtl/odu_gmp_payload_gen.sv
// GMP payload word generator: emits client data or stuff per channel slot, tracks Cm and frame sync.
// Optional build macro ODU_PRBS_STUFF_EN fills stuff words from a PRBS-15 instead of STUFF_PATTERN.
module odu_gmp_payload_gen #(
    parameter int                DATA_W        = 8,
    parameter int                FRAME_SLOTS   = 15232,
    parameter int                SLOT_W        = 14,
    parameter logic [DATA_W-1:0] STUFF_PATTERN = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_chid,
    input  logic              chid_type,
    input  logic              enable_gen_data,
    input  logic              frame_sync,
    input  logic              client_valid,
    input  logic [DATA_W-1:0] client_data,
    output logic              client_pop,
    output logic              pl_valid,
    output logic [DATA_W-1:0] pl_data,
    output logic              pl_is_data,
    output logic              pl_sof,
    output logic              frame_type,
    output logic [SLOT_W-1:0] cm_count,
    output logic              cm_valid,
    output logic              underflow,
    output logic              sync_err,
    output logic              run
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_SLOTS - 1);

    state_t            state, state_nxt;
    logic [SLOT_W-1:0] slot, acc;
    logic [SLOT_W-1:0] slot_cur, acc_sum;
    logic              take, misaligned, data_req, pop;
    logic [DATA_W-1:0] stuff_word;

    assign run        = (state == RUN);
    assign take       = run & enable_chid;
    assign misaligned = run & frame_sync & (slot != '0);
    assign data_req   = take & enable_gen_data;
    assign pop        = data_req & client_valid;
    assign client_pop = pop;

    // A misaligned sync re-anchors the frame on the current cycle, so this slot becomes slot 0.
    assign slot_cur = misaligned ? '0 : slot;
    assign acc_sum  = (misaligned ? '0 : acc) + SLOT_W'(data_req);

`ifdef ODU_PRBS_STUFF_EN
    logic [14:0] lfsr, lfsr_adv;

    always_comb begin
        lfsr_adv   = lfsr;
        stuff_word = '0;
        for (int i = 0; i < DATA_W; i++) begin
            stuff_word[DATA_W-1-i] = lfsr_adv[14];
            lfsr_adv = {lfsr_adv[13:0], lfsr_adv[14] ^ lfsr_adv[13]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr <= 15'h7FFF;
        else if (take && !pop)
            lfsr <= lfsr_adv;
    end
`else
    assign stuff_word = STUFF_PATTERN;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: next-state is defaulted to the current state first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        if (state == IDLE && frame_sync)
            state_nxt = RUN;
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot       <= '0;
            acc        <= '0;
            pl_valid   <= 1'b0;
            pl_data    <= '0;
            pl_is_data <= 1'b0;
            pl_sof     <= 1'b0;
            frame_type <= 1'b0;
            cm_count   <= '0;
            cm_valid   <= 1'b0;
            underflow  <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            cm_valid   <= 1'b0;
            pl_valid   <= take;
            pl_sof     <= take & (slot_cur == '0);
            pl_is_data <= pop;
            if (take)
                pl_data <= pop ? client_data : stuff_word;
            if (data_req && !client_valid)
                underflow <= 1'b1;
            if (misaligned) begin
                sync_err   <= 1'b1;
                frame_type <= chid_type;
            end

            if (state == IDLE) begin
                if (frame_sync) begin
                    frame_type <= chid_type;
                    slot       <= enable_chid ? SLOT_W'(1) : '0;
                    acc        <= '0;
                end
            end else if (take) begin
                if (slot_cur == LAST_SLOT) begin
                    slot       <= '0;
                    acc        <= '0;
                    cm_count   <= acc_sum;
                    cm_valid   <= 1'b1;
                    frame_type <= chid_type;
                end else begin
                    slot <= slot_cur + SLOT_W'(1);
                    acc  <= acc_sum;
                end
            end else if (misaligned) begin
                slot <= '0;
                acc  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_odu_gmp_payload_gen.sv
// Randomised and directed bench for odu_gmp_payload_gen with an abstract per-slot reference model.
// Build with ODU_PRBS_STUFF_EN defined to check the PRBS stuff variant.
module tb_odu_gmp_payload_gen;

    localparam int DATA_W      = 8;
    localparam int FRAME_SLOTS = 8;
    localparam int SLOT_W      = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable_chid = 1'b0;
    logic              chid_type = 1'b0;
    logic              enable_gen_data = 1'b0;
    logic              frame_sync = 1'b0;
    logic              client_valid = 1'b0;
    logic [DATA_W-1:0] client_data = '0;
    logic              client_pop;
    logic              pl_valid;
    logic [DATA_W-1:0] pl_data;
    logic              pl_is_data;
    logic              pl_sof;
    logic              frame_type;
    logic [SLOT_W-1:0] cm_count;
    logic              cm_valid;
    logic              underflow;
    logic              sync_err;
    logic              run;

    odu_gmp_payload_gen #(
        .DATA_W(DATA_W), .FRAME_SLOTS(FRAME_SLOTS), .SLOT_W(SLOT_W), .STUFF_PATTERN(8'h00)
    ) dut (
        .clk(clk), .rst(rst), .enable_chid(enable_chid), .chid_type(chid_type),
        .enable_gen_data(enable_gen_data), .frame_sync(frame_sync),
        .client_valid(client_valid), .client_data(client_data), .client_pop(client_pop),
        .pl_valid(pl_valid), .pl_data(pl_data), .pl_is_data(pl_is_data), .pl_sof(pl_sof),
        .frame_type(frame_type), .cm_count(cm_count), .cm_valid(cm_valid),
        .underflow(underflow), .sync_err(sync_err), .run(run)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state: frame position, data counts and the last emitted word.
    bit           m_run, m_ftype, m_under, m_serr;
    int           m_slot, m_cm, m_cm_count;
    logic [7:0]   m_data;
    bit           e_pop, e_valid, e_sof, e_isd, e_cmv;
    logic [7:0]   cli_next = 8'hA0;

`ifdef ODU_PRBS_STUFF_EN
    // PRBS-15 as a bit sequence: b[n] = b[n-14] ^ b[n-15], first 15 bits all ones.
    bit pb[$];
    int pidx;
`endif

    function automatic logic [7:0] next_stuff();
`ifdef ODU_PRBS_STUFF_EN
        logic [7:0] w;
        for (int i = 0; i < 8; i++) begin
            while (pb.size() <= pidx)
                pb.push_back(pb[pb.size()-14] ^ pb[pb.size()-15]);
            w[7-i] = pb[pidx];
            pidx++;
        end
        return w;
`else
        return 8'h00;
`endif
    endfunction

    task automatic model_reset();
        m_run = 0; m_ftype = 0; m_under = 0; m_serr = 0;
        m_slot = 0; m_cm = 0; m_cm_count = 0; m_data = 8'h00;
`ifdef ODU_PRBS_STUFF_EN
        pb.delete();
        for (int i = 0; i < 15; i++) pb.push_back(1'b1);
        pidx = 0;
`endif
    endtask

    task automatic model_step(input bit chid, input bit gen, input bit cv, input bit fs, input bit ct);
        e_pop = 0; e_valid = 0; e_sof = 0; e_isd = 0; e_cmv = 0;
        if (!m_run) begin
            if (fs) begin
                m_run = 1; m_ftype = ct; m_cm = 0;
                m_slot = chid ? 1 : 0;
            end
        end else begin
            if (fs && m_slot != 0) begin
                m_serr = 1; m_slot = 0; m_cm = 0; m_ftype = ct;
            end
            if (chid) begin
                e_valid = 1;
                e_sof   = (m_slot == 0);
                if (gen) begin
                    m_cm++;
                    if (cv) begin
                        e_pop = 1; e_isd = 1; m_data = cli_next;
                    end else begin
                        m_under = 1; m_data = next_stuff();
                    end
                end else begin
                    m_data = next_stuff();
                end
                m_slot++;
                if (m_slot == FRAME_SLOTS) begin
                    m_slot = 0; m_cm_count = m_cm; m_cm = 0; e_cmv = 1; m_ftype = ct;
                end
            end
        end
    endtask

    task automatic do_slot(input bit chid, input bit gen, input bit cv, input bit fs, input bit ct);
        @(negedge clk);
        enable_chid = chid; enable_gen_data = gen; client_valid = cv;
        frame_sync = fs; chid_type = ct; client_data = cli_next;
        model_step(chid, gen, cv, fs, ct);
        #1;
        check("client_pop", client_pop, e_pop);
        if (e_pop) cli_next = cli_next + 8'h01;
        @(posedge clk);
        #1;
        check("pl_valid", pl_valid, e_valid);
        if (e_valid) begin
            check("pl_is_data", pl_is_data, e_isd);
            check("pl_sof", pl_sof, e_sof);
        end
        check("pl_data", pl_data, m_data);
        check("cm_valid", cm_valid, e_cmv);
        check("cm_count", cm_count, m_cm_count);
        check("underflow", underflow, m_under);
        check("sync_err", sync_err, m_serr);
        check("frame_type", frame_type, m_ftype);
        check("run", run, m_run);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        enable_chid = 0; enable_gen_data = 0; client_valid = 0; frame_sync = 0; chid_type = 0;
        model_reset();
        #1;
        check("rst_pl_valid", pl_valid, 0);
        check("rst_pl_data", pl_data, 0);
        check("rst_cm_valid", cm_valid, 0);
        check("rst_cm_count", cm_count, 0);
        check("rst_flags", {underflow, sync_err, frame_type, run, pl_sof, pl_is_data}, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // IDLE: slots with data requests are ignored until frame_sync.
        do_slot(1, 1, 1, 0, 0);
        do_slot(1, 1, 1, 0, 0);

        // Basic frame: alternating data/stuff, A0..A3 expected on data slots.
        cli_next = 8'hA0;
        do_slot(0, 0, 1, 1, 0);
        for (int k = 0; k < FRAME_SLOTS; k++) do_slot(1, (k % 2) == 0, 1, 0, 0);
        check("basic_cm_count", cm_count, 4);

        // Underflow on slot 3 still counts as a data slot.
        for (int k = 0; k < FRAME_SLOTS; k++) do_slot(1, (k % 2) == 1, k != 3, 0, 0);
        check("uf_cm_count", cm_count, 4);
        do_slot(0, 0, 0, 0, 0);
        check("uf_sticky", underflow, 1);

        // Misaligned sync at slot 5, then a full frame after it.
        for (int k = 0; k < 5; k++) do_slot(1, 1, 1, 0, 0);
        do_slot(1, 1, 1, 1, 0);
        for (int k = 1; k < FRAME_SLOTS; k++) do_slot(1, 1, 1, 0, 0);
        check("resync_cm_count", cm_count, 8);

        // frame_type only follows chid_type at the wrap.
        for (int k = 0; k < FRAME_SLOTS; k++) do_slot(1, 0, 1, 0, k >= 3);
        check("type_latched", frame_type, 1);

        // All-stuff frames exercise the stuff word sequence.
        for (int k = 0; k < 2 * FRAME_SLOTS; k++) do_slot(1, 0, 1, 0, 1);

        // Reset mid-frame: back to IDLE, no partial Cm report.
        for (int k = 0; k < 3; k++) do_slot(1, 1, 1, 0, 1);
        do_reset();
        do_slot(0, 0, 0, 0, 0);
        do_slot(1, 1, 1, 0, 0);
        do_slot(0, 0, 1, 1, 0);

        // Randomised traffic with occasional frame_sync pulses.
        for (int k = 0; k < 600; k++)
            do_slot($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 4) != 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 1) == 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/odu_gmp_payload_gen.md
Name: odu_gmp_payload_gen

Overview:
- Downstream consumer of the GMP sigma-delta counter's `enable_gen_data` decision.
- On every channel slot (`enable_chid`), emits one payload word into the OPU payload stream:
  - a client data word when the counter requests data;
  - a stuff word otherwise.
- Tracks slot position within the payload frame, counts data words per frame (Cm) and flags client underflow and frame-sync errors.
- Sits between the client ingress FIFO and the OPU framer.

Parameters:
- DATA_W, 8, payload word width in bits.
- FRAME_SLOTS, 15232, channel slots per payload frame (4 x 3808).
- SLOT_W, 14, width of the slot counter and Cm; must satisfy 2^SLOT_W >= FRAME_SLOTS.
- STUFF_PATTERN, 8'h00, constant stuff word (non-PRBS build).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- enable_chid  input  1  channel slot strobe, one payload word per asserted cycle.
- chid_type  input  1  0 = ODU0 mapping, 1 = ODU2 mapping; sampled at frame start.
- enable_gen_data  input  1  GMP decision from the sigma-delta counter, valid with enable_chid.
- frame_sync  input  1  single-cycle pulse marking slot 0 of a payload frame.
- client_valid  input  1  client FIFO has a word.
- client_data  input  DATA_W  client FIFO head word.
- client_pop  output  1  combinational pop of the client FIFO.
- pl_valid  output  1  payload word valid.
- pl_data  output  DATA_W  payload word.
- pl_is_data  output  1  1 = client word, 0 = stuff.
- pl_sof  output  1  marks first word of a frame.
- frame_type  output  1  chid_type latched for the current frame.
- cm_count  output  SLOT_W  data words in the last completed frame.
- cm_valid  output  1  one-cycle pulse when cm_count updates.
- underflow  output  1  sticky; client empty when data requested.
- sync_err  output  1  sticky; frame_sync arrived at a non-zero slot.
- run  output  1  1 while in state RUN.

Behaviour:
- Reset values: all outputs 0; slot counter 0; Cm accumulator 0; state IDLE.
- State IDLE:
  - pl_valid stays 0 and client_pop stays 0.
  - frame_sync moves to RUN and latches chid_type into frame_type.
  - The slot carrying the frame_sync (if enable_chid is high) is slot 0.
- State RUN: on each enable_chid cycle, the word is registered with 1-cycle latency.
  - If enable_gen_data = 1 and client_valid = 1:
    - client_pop = 1 in the same cycle;
    - next cycle: pl_data = client_data, pl_is_data = 1;
    - Cm accumulator +1.
  - If enable_gen_data = 1 and client_valid = 0:
    - stuff word emitted, pl_is_data = 0;
    - underflow set (sticky);
    - Cm still +1. The counter has already debited; the receiver sees a data slot containing fill.
  - If enable_gen_data = 0: stuff word emitted, pl_is_data = 0, no pop.
  - In all three cases pl_valid = 1, and pl_sof = 1 when slot = 0.
- Cycles without enable_chid: pl_valid = 0; pl_data holds its last value.
- client_pop is never asserted without enable_chid & enable_gen_data & client_valid & run.
- Slot counter:
  - Increments per enable_chid and wraps from FRAME_SLOTS-1 to 0.
  - At the wrap, cm_count takes the final accumulator value (including the last slot), cm_valid pulses on the following cycle, and the accumulator restarts at 0.
  - frame_type re-latches chid_type at each wrap. Mid-frame chid_type changes are ignored.
- frame_sync while in RUN:
  - At slot 0 (expected position): no action.
  - At any other slot:
    - sync_err set;
    - slot counter forced so the current slot becomes slot 0;
    - Cm accumulator discarded with no cm_valid;
    - frame_type re-latched.
- frame_sync coinciding with the wrap is the normal aligned case.
- underflow and sync_err clear only on rst.
- Asserting rst mid-frame returns the block to IDLE immediately. No partial cm_valid is issued.

Optional Feature:
- Macro: ODU_PRBS_STUFF_EN.
- Defined:
  - Stuff words carry successive bits of a PRBS-15 (x^15+x^14+1), DATA_W bits per stuff word, MSB first.
  - Seed is 15'h7FFF after reset.
  - The LFSR advances only when a stuff word is emitted.
- Undefined: stuff words equal STUFF_PATTERN and no LFSR is instantiated.

Test Plan:
- Bench setup: FRAME_SLOTS = 8, DATA_W = 8.
- Reset/IDLE: rst pulse, then enable_chid with enable_gen_data high and no frame_sync → client_pop 0, pl_valid 0, run 0.
- Basic frame: frame_sync, then 8 enable_chid cycles, enable_gen_data = 1,0,1,0,1,0,1,0, client_data 8'hA0..A3 always valid → pl_data A0,00,A1,00,A2,00,A3,00; pl_sof on the first word; cm_count = 4 with cm_valid one cycle after the 8th word.
- Underflow: enable_gen_data = 1 on slot 3 with client_valid = 0 → pl_is_data 0, stuff word output, underflow = 1 and stays set, cm_count for that frame still counts slot 3.
- Misaligned sync: frame_sync at slot 5 in RUN → sync_err = 1, the next word has pl_sof = 1, no cm_valid for the broken frame, and the following full frame reports a correct cm_count.
- Type latch: chid_type toggles 0→1 at slot 3 → frame_type stays 0 until the wrap, then reads 1.
- PRBS build (ODU_PRBS_STUFF_EN): all stuff slots → first stuff word 8'hFF; subsequent words match a reference PRBS-15 model; data slots do not advance the LFSR.
